// File: rtl/bram_tdp_port_arbiter_if.sv
// Requester, response and BRAM-port signal bundle for bram_tdp_port_arbiter.
// slave = arbiter side, master = clients plus BRAM side.
interface bram_tdp_port_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned DWIDTH = 36
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*AWIDTH-1:0] req_addr;
  logic [NREQ*DWIDTH-1:0] req_wdata;

  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [DWIDTH-1:0]      rsp_data;

  logic                   bram_rce;
  logic [AWIDTH-1:0]      bram_ra;
  logic                   bram_wce;
  logic [AWIDTH-1:0]      bram_wa;
  logic [DWIDTH-1:0]      bram_wd;
  logic [DWIDTH-1:0]      bram_rq;

  logic                   init_busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, bram_rq,
    output req_ready, rsp_valid, rsp_id, rsp_data,
    output bram_rce, bram_ra, bram_wce, bram_wa, bram_wd, init_busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, bram_rq,
    input  req_ready, rsp_valid, rsp_id, rsp_data,
    input  bram_rce, bram_ra, bram_wce, bram_wa, bram_wd, init_busy
  );
endinterface

// File: rtl/bram_tdp_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NREQ requesters, with tagged read responses.
// Optional post-reset zero-fill of the whole BRAM enabled by BRAM_TDP_ARB_INIT_CLEAR_EN.
module bram_tdp_port_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned DWIDTH = 36
) (
  input  logic                  clk,
  input  logic                  rst,
  bram_tdp_port_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic                bram_rce_q, bram_rce_d;
  logic                bram_wce_q, bram_wce_d;
  logic [AWIDTH-1:0]   bram_ra_q, bram_ra_d;
  logic [AWIDTH-1:0]   bram_wa_q, bram_wa_d;
  logic [DWIDTH-1:0]   bram_wd_q, bram_wd_d;
  logic [IDW-1:0]      cmd_id_q, cmd_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;

  logic                arb_en;
  logic                gnt_found;
  logic [IDW-1:0]      gnt_idx;
  logic [NREQ-1:0]     gnt_vec;
  logic                accept;
  int unsigned         cand;

  logic [AWIDTH-1:0]   addr_arr  [NREQ];
  logic [DWIDTH-1:0]   wdata_arr [NREQ];

`ifdef BRAM_TDP_ARB_INIT_CLEAR_EN
  localparam state_e RST_STATE = ST_CLEAR;
  logic                init_busy_q, init_busy_d;
  logic [AWIDTH-1:0]   clr_cnt_q, clr_cnt_d;

  // The final clear write is still busy on the bus even though state_q is already RUN.
  assign arb_en        = (state_q == ST_RUN) && !init_busy_q;
  assign bus.init_busy = init_busy_q;
`else
  localparam state_e RST_STATE = ST_RUN;

  assign arb_en        = (state_q == ST_RUN);
  assign bus.init_busy = 1'b0;
`endif

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[g*AWIDTH +: AWIDTH];
    assign wdata_arr[g] = bus.req_wdata[g*DWIDTH +: DWIDTH];
  end

  // Round-robin scan starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!gnt_found && bus.req_valid[IDW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(cand);
      end
    end
  end

  assign gnt_vec       = (arb_en && gnt_found) ? (NREQ'(1) << gnt_idx) : '0;
  assign bus.req_ready = gnt_vec;
  assign accept        = |(bus.req_valid & gnt_vec);

  // Next-state and BRAM command generation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    bram_rce_d  = 1'b0;
    bram_wce_d  = 1'b0;
    bram_ra_d   = bram_ra_q;
    bram_wa_d   = bram_wa_q;
    bram_wd_d   = bram_wd_q;
    cmd_id_d    = cmd_id_q;
    rsp_valid_d = bram_rce_q;
    rsp_id_d    = cmd_id_q;
`ifdef BRAM_TDP_ARB_INIT_CLEAR_EN
    init_busy_d = 1'b0;
    clr_cnt_d   = clr_cnt_q;
`endif

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          ptr_d      = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          bram_rce_d = ~bus.req_we[gnt_idx];
          bram_wce_d = bus.req_we[gnt_idx];
          bram_ra_d  = addr_arr[gnt_idx];
          bram_wa_d  = addr_arr[gnt_idx];
          cmd_id_d   = gnt_idx;
          if (bus.req_we[gnt_idx]) begin
            bram_wd_d = wdata_arr[gnt_idx];
          end
        end
      end
      ST_CLEAR: begin
`ifdef BRAM_TDP_ARB_INIT_CLEAR_EN
        init_busy_d = 1'b1;
        bram_wce_d  = 1'b1;
        bram_ra_d   = clr_cnt_q;
        bram_wa_d   = clr_cnt_q;
        bram_wd_d   = '0;
        clr_cnt_d   = clr_cnt_q + AWIDTH'(1);
        if (clr_cnt_q == '1) begin
          state_d = ST_RUN;
        end
`else
        state_d = ST_RUN;
`endif
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      ptr_q       <= '0;
      bram_rce_q  <= 1'b0;
      bram_wce_q  <= 1'b0;
      bram_ra_q   <= '0;
      bram_wa_q   <= '0;
      bram_wd_q   <= '0;
      cmd_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      bram_rce_q  <= bram_rce_d;
      bram_wce_q  <= bram_wce_d;
      bram_ra_q   <= bram_ra_d;
      bram_wa_q   <= bram_wa_d;
      bram_wd_q   <= bram_wd_d;
      cmd_id_q    <= cmd_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

`ifdef BRAM_TDP_ARB_INIT_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_busy_q <= 1'b1;
      clr_cnt_q   <= '0;
    end else begin
      init_busy_q <= init_busy_d;
      clr_cnt_q   <= clr_cnt_d;
    end
  end
`endif

  assign bus.bram_rce  = bram_rce_q;
  assign bus.bram_wce  = bram_wce_q;
  assign bus.bram_ra   = bram_ra_q;
  assign bus.bram_wa   = bram_wa_q;
  assign bus.bram_wd   = bram_wd_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_valid_q ? bus.bram_rq : '0;
endmodule

// File: tb/tb_bram_tdp_port_arbiter.sv
// Directed bench for bram_tdp_port_arbiter with a behavioural 1-cycle-latency BRAM.
// Clear-sequence scenarios run when BRAM_TDP_ARB_INIT_CLEAR_EN is defined.
module tb_bram_tdp_port_arbiter;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned AWIDTH = 10;
  localparam int unsigned DWIDTH = 36;
  localparam int unsigned DEPTH  = 1 << AWIDTH;
  localparam int unsigned AW_ALL = NREQ * AWIDTH;
  localparam int unsigned DW_ALL = NREQ * DWIDTH;
`ifdef BRAM_TDP_ARB_INIT_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rq_r;

  bram_tdp_port_arbiter_if #(.NREQ(NREQ), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

  bram_tdp_port_arbiter #(.NREQ(NREQ), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DWIDTH-1:0] pat(input int unsigned a);
    return 36'hF_0000_0000 | DWIDTH'(a);
  endfunction

  // BRAM model: reset preloads a non-zero pattern so zero-fill is observable.
  always @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    end else begin
      if (bus.bram_wce) mem[bus.bram_wa] <= bus.bram_wd;
      if (bus.bram_rce) rq_r <= mem[bus.bram_ra];
    end
  end
  assign bus.bram_rq = rq_r;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned idx, input logic we,
                         input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
    bus.req_we    = (bus.req_we & ~(NREQ'(1) << idx)) | (NREQ'(we) << idx);
    bus.req_addr  = (bus.req_addr & ~(AW_ALL'({AWIDTH{1'b1}}) << (idx * AWIDTH)))
                  | (AW_ALL'(a) << (idx * AWIDTH));
    bus.req_wdata = (bus.req_wdata & ~(DW_ALL'({DWIDTH{1'b1}}) << (idx * DWIDTH)))
                  | (DW_ALL'(d) << (idx * DWIDTH));
  endtask

  task automatic wait_clear_done();
`ifdef BRAM_TDP_ARB_INIT_CLEAR_EN
    int c = 0;
    while (bus.init_busy && c < 2000) begin
      tick();
      c++;
    end
    check_eq("clear_done_timeout", 64'(bus.init_busy), 64'(0));
`endif
  endtask

  task automatic reset_dut();
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wait_clear_done();
  endtask

`ifdef BRAM_TDP_ARB_INIT_CLEAR_EN
  // Walks one full clear sequence, requests held high throughout.
  task automatic run_clear_check(input string tag);
    int unsigned ea = 0;
    int bad = 0;
    int busy_cycles = 0;
    bus.req_valid = '1;
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (!bus.init_busy) break;
      busy_cycles++;
      if (!(bus.bram_wce && !bus.bram_rce && bus.bram_wa == AWIDTH'(ea)
            && bus.bram_wd == '0 && bus.req_ready == '0)) bad++;
      ea++;
    end
    bus.req_valid = '0;
    check_eq({tag, "_bad_cycles"}, 64'(bad), 64'(0));
    check_eq({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(1024));
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #2 rst = 1'b1;
    tick();
    tick();
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check_eq("rst_rsp_id",    64'(bus.rsp_id),    64'(0));
    check_eq("rst_bram_rce",  64'(bus.bram_rce),  64'(0));
    check_eq("rst_bram_wce",  64'(bus.bram_wce),  64'(0));
    check_eq("rst_bram_ra",   64'(bus.bram_ra),   64'(0));
    check_eq("rst_bram_wa",   64'(bus.bram_wa),   64'(0));
    check_eq("rst_bram_wd",   64'(bus.bram_wd),   64'(0));
    check_eq("rst_init_busy", 64'(bus.init_busy), 64'(CLR_EN));
    rst = 1'b0;
    wait_clear_done();

    // Single read from requester 0: grant, command, response timing.
    set_req(0, 1'b0, 10'd5, '0);
    bus.req_valid = 4'b0001;
    #1 check_eq("t1_ready", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    bus.req_valid = '0;
    check_eq("t1_rce", 64'(bus.bram_rce), 64'(1));
    check_eq("t1_wce", 64'(bus.bram_wce), 64'(0));
    check_eq("t1_ra",  64'(bus.bram_ra),  64'(5));
    check_eq("t1_wa",  64'(bus.bram_wa),  64'(5));
    check_eq("t1_rsp_early", 64'(bus.rsp_valid), 64'(0));
    tick();
    check_eq("t1_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    check_eq("t1_rsp_id",    64'(bus.rsp_id),    64'(0));
    check_eq("t1_rsp_data",  64'(bus.rsp_data),  64'(CLR_EN ? '0 : pat(5)));
    check_eq("t1_rce_idle",  64'(bus.bram_rce),  64'(0));
    tick();
    check_eq("t1_rsp_pulse", 64'(bus.rsp_valid), 64'(0));

    // All requesters valid: strict rotation 0,1,2,3,0,1,2,3.
    reset_dut();
    for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b0, AWIDTH'(10 + i), '0);
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1 check_eq($sformatf("t2_ready_%0d", c), 64'(bus.req_ready), 64'(1) << (c % 4));
      tick();
      check_eq($sformatf("t2_ra_%0d", c), 64'(bus.bram_ra), 64'(10 + (c % 4)));
      if (c >= 1) begin
        check_eq($sformatf("t2_rsp_valid_%0d", c), 64'(bus.rsp_valid), 64'(1));
        check_eq($sformatf("t2_rsp_id_%0d", c), 64'(bus.rsp_id), 64'((c - 1) % 4));
      end
    end
    bus.req_valid = '0;
    tick();
    check_eq("t2_last_rsp_id",   64'(bus.rsp_id),   64'(3));
    check_eq("t2_last_rsp_data", 64'(bus.rsp_data), 64'(CLR_EN ? '0 : pat(13)));
    check_eq("t2_idle_rce",      64'(bus.bram_rce), 64'(0));
    check_eq("t2_idle_ra_hold",  64'(bus.bram_ra),  64'(13));

    // Write by req1 then read of same address by req2 returns the new data.
    set_req(1, 1'b1, 10'd7, 36'hABC);
    bus.req_valid = 4'b0010;
    #1 check_eq("t3_ready_w", 64'(bus.req_ready), 64'(4'b0010));
    tick();
    set_req(2, 1'b0, 10'd7, '0);
    bus.req_valid = 4'b0100;
    check_eq("t3_wce", 64'(bus.bram_wce), 64'(1));
    check_eq("t3_rce", 64'(bus.bram_rce), 64'(0));
    check_eq("t3_wa",  64'(bus.bram_wa),  64'(7));
    check_eq("t3_wd",  64'(bus.bram_wd),  64'(36'hABC));
    #1 check_eq("t3_ready_r", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    bus.req_valid = '0;
    check_eq("t3_rd_rce", 64'(bus.bram_rce), 64'(1));
    check_eq("t3_rd_ra",  64'(bus.bram_ra),  64'(7));
    check_eq("t3_no_wr_rsp", 64'(bus.rsp_valid), 64'(0));
    tick();
    check_eq("t3_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    check_eq("t3_rsp_id",    64'(bus.rsp_id),    64'(2));
    check_eq("t3_rsp_data",  64'(bus.rsp_data),  64'(36'hABC));

    // After req2 wins, req3 outranks req0.
    set_req(2, 1'b0, 10'd20, '0);
    bus.req_valid = 4'b0100;
    #1 check_eq("t4_ready_2", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    set_req(0, 1'b0, 10'd30, '0);
    set_req(3, 1'b0, 10'd33, '0);
    bus.req_valid = 4'b1001;
    #1 check_eq("t4_ready_3", 64'(bus.req_ready), 64'(4'b1000));
    tick();
    bus.req_valid = 4'b0001;
    check_eq("t4_ra_3", 64'(bus.bram_ra), 64'(33));
    #1 check_eq("t4_ready_0", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    bus.req_valid = '0;
    check_eq("t4_ra_0",     64'(bus.bram_ra), 64'(30));
    check_eq("t4_rsp_id_3", 64'(bus.rsp_id),  64'(3));
    tick();
    check_eq("t4_rsp_valid_0", 64'(bus.rsp_valid), 64'(1));
    check_eq("t4_rsp_id_0",    64'(bus.rsp_id),    64'(0));

    // req0 withdraws before being granted: no command is issued for it.
    set_req(0, 1'b0, 10'd40, '0);
    set_req(1, 1'b1, 10'd41, 36'h123);
    bus.req_valid = 4'b0011;
    #1 check_eq("t5_ready", 64'(bus.req_ready), 64'(4'b0010));
    tick();
    bus.req_valid = '0;
    check_eq("t5_wce", 64'(bus.bram_wce), 64'(1));
    check_eq("t5_wa",  64'(bus.bram_wa),  64'(41));
    #1 check_eq("t5_ready_none", 64'(bus.req_ready), 64'(0));
    tick();
    check_eq("t5_idle_rce",  64'(bus.bram_rce), 64'(0));
    check_eq("t5_idle_wce",  64'(bus.bram_wce), 64'(0));
    check_eq("t5_ra_hold",   64'(bus.bram_ra),  64'(41));
    check_eq("t5_wd_hold",   64'(bus.bram_wd),  64'(36'h123));
    tick();
    check_eq("t5_no_rsp", 64'(bus.rsp_valid), 64'(0));

`ifdef BRAM_TDP_ARB_INIT_CLEAR_EN
    // Full clear after reset, then a read of a cleared location.
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b0, AWIDTH'(100), '0);
    run_clear_check("c1");
    set_req(0, 1'b0, 10'd100, '0);
    bus.req_valid = 4'b0001;
    #1 check_eq("c1_ready", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    bus.req_valid = '0;
    tick();
    check_eq("c1_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    check_eq("c1_rsp_data",  64'(bus.rsp_data),  64'(0));

    // Reset in the middle of a clear restarts it from address 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    begin
      int c = 0;
      while (!(bus.bram_wce && bus.bram_wa == AWIDTH'(500)) && c < 2000) begin
        tick();
        c++;
      end
      check_eq("c2_reach_500", 64'(bus.bram_wa), 64'(500));
    end
    rst = 1'b1;
    #1;
    check_eq("c2_rst_wce",  64'(bus.bram_wce),  64'(0));
    check_eq("c2_rst_busy", 64'(bus.init_busy), 64'(1));
    tick();
    rst = 1'b0;
    run_clear_check("c2");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
